// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath constants: native word width and operand-forwarding select codes.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam int unsigned FWD_RF  = 0;
  localparam int unsigned FWD_EX  = 1;
  localparam int unsigned FWD_MEM = 2;
  localparam int unsigned FWD_WB  = 3;

endpackage

// File: rtl/pipe_skid_reg.sv
// Registered valid/ready pipeline stage with a one-entry skid buffer and synchronous flush.
// in_ready depends only on the skid flop, so there is no combinational path from out_ready.
module pipe_skid_reg #(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         flush,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] skid_data;
  logic         skid_valid;
  logic         accept;
  logic         advance;

  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign advance  = ~out_valid | out_ready;

  // Valid flags: flush wins, then the skid entry refills the output ahead of new data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (advance) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= accept;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
    end
  end

  // Payload registers follow the same priority; they simply hold when nothing moves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      skid_data <= '0;
    end else if (!flush) begin
      if (advance) begin
        if (skid_valid) begin
          out_data <= skid_data;
        end else if (accept) begin
          out_data <= in_data;
        end
      end else if (accept) begin
        skid_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// N-way WIDTH-bit select feeding a skid-buffered pipeline register; flags selects beyond N-1.
module mux_n_pipe
  import riscv_pkg::*;
#(
  parameter  int unsigned WIDTH = XLEN,
  parameter  int unsigned N     = 4,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_sel_err,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [WIDTH-1:0] sel_val;
  logic             sel_err;
  logic [WIDTH:0]   stage_out;

  // Out-of-range selects fall through to zero.
  always_comb begin
    sel_val = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_val = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  generate
    if (N == (1 << SEL_W)) begin : g_pow2
      assign sel_err = 1'b0;
    end else begin : g_npow2
      assign sel_err = (sel >= SEL_W'(N));
    end
  endgenerate

  pipe_skid_reg #(
    .W (WIDTH + 1)
  ) u_stage (
    .clk       (clk),
    .reset     (reset),
    .in_data   ({sel_val, sel_err}),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (stage_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign out_data    = stage_out[WIDTH:1];
  assign out_sel_err = stage_out[0];

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe: vector table on an N=4 instance plus hand sequences for N=3 and async reset.
module tb_mux_n_pipe;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // N=4 instance
  logic [127:0] in4;
  logic [1:0]   sel4;
  logic         iv4, ir4, fl4, ov4, or4, err4;
  logic [31:0]  od4;

  // N=3 instance
  logic [95:0]  in3;
  logic [1:0]   sel3;
  logic         iv3, ir3, fl3, ov3, or3, err3;
  logic [31:0]  od3;

  int checks = 0;
  int errors = 0;

  mux_n_pipe #(.WIDTH(32), .N(4)) dut4 (
    .clk(clk), .reset(reset), .in_data(in4), .sel(sel4), .in_valid(iv4), .in_ready(ir4),
    .flush(fl4), .out_data(od4), .out_sel_err(err4), .out_valid(ov4), .out_ready(or4)
  );

  mux_n_pipe #(.WIDTH(32), .N(3)) dut3 (
    .clk(clk), .reset(reset), .in_data(in3), .sel(sel3), .in_valid(iv3), .in_ready(ir3),
    .flush(fl3), .out_data(od3), .out_sel_err(err3), .out_valid(ov3), .out_ready(or3)
  );

  typedef struct {
    logic [1:0]  sel;
    logic        in_valid;
    logic        out_ready;
    logic        flush;
    logic        chk_data;
    logic [31:0] exp_data;
    logic        exp_valid;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    in4 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    in3 = {32'hCCCC2222, 32'hBBBB1111, 32'hAAAA0000};
    sel4 = '0; iv4 = 1'b0; or4 = 1'b1; fl4 = 1'b0;
    sel3 = '0; iv3 = 1'b0; or3 = 1'b1; fl3 = 1'b0;

    //          sel              iv    ordy  flush chk   data           valid ready
    vecs[0]  = '{2'(FWD_MEM),    1'b1, 1'b1, 1'b0, 1'b1, 32'h33333333, 1'b1, 1'b1};
    vecs[1]  = '{2'(FWD_RF),     1'b1, 1'b1, 1'b0, 1'b1, 32'h11111111, 1'b1, 1'b1};
    vecs[2]  = '{2'(FWD_EX),     1'b1, 1'b1, 1'b0, 1'b1, 32'h22222222, 1'b1, 1'b1};
    vecs[3]  = '{2'(FWD_MEM),    1'b1, 1'b1, 1'b0, 1'b1, 32'h33333333, 1'b1, 1'b1};
    vecs[4]  = '{2'(FWD_WB),     1'b1, 1'b1, 1'b0, 1'b1, 32'h44444444, 1'b1, 1'b1};
    vecs[5]  = '{2'd0,           1'b0, 1'b1, 1'b0, 1'b1, 32'h44444444, 1'b0, 1'b1};
    vecs[6]  = '{2'd1,           1'b1, 1'b0, 1'b0, 1'b1, 32'h22222222, 1'b1, 1'b1};
    vecs[7]  = '{2'd3,           1'b1, 1'b0, 1'b0, 1'b1, 32'h22222222, 1'b1, 1'b0};
    vecs[8]  = '{2'd0,           1'b1, 1'b0, 1'b0, 1'b1, 32'h22222222, 1'b1, 1'b0};
    vecs[9]  = '{2'd0,           1'b1, 1'b1, 1'b0, 1'b1, 32'h44444444, 1'b1, 1'b1};
    vecs[10] = '{2'd0,           1'b1, 1'b1, 1'b0, 1'b1, 32'h11111111, 1'b1, 1'b1};
    vecs[11] = '{2'd0,           1'b0, 1'b1, 1'b0, 1'b1, 32'h11111111, 1'b0, 1'b1};
    vecs[12] = '{2'd1,           1'b1, 1'b0, 1'b0, 1'b1, 32'h22222222, 1'b1, 1'b1};
    vecs[13] = '{2'd2,           1'b1, 1'b0, 1'b0, 1'b1, 32'h22222222, 1'b1, 1'b0};
    vecs[14] = '{2'd3,           1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[15] = '{2'd0,           1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[16] = '{2'd0,           1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[17] = '{2'd3,           1'b1, 1'b1, 1'b0, 1'b1, 32'h44444444, 1'b1, 1'b1};
    vecs[18] = '{2'd0,           1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1};

    reset = 1'b1;
    #12;
    check("reset out_valid", 32'(ov4), 32'd0);
    check("reset in_ready", 32'(ir4), 32'd1);
    check("reset out_data", od4, 32'h0);
    check("reset out_sel_err", 32'(err4), 32'd0);
    reset = 1'b0;
    step();

    // Table vectors on N=4: inputs held for one cycle, outputs checked just after the edge.
    for (int i = 0; i < 19; i++) begin
      sel4 = vecs[i].sel; iv4 = vecs[i].in_valid; or4 = vecs[i].out_ready; fl4 = vecs[i].flush;
      step();
      check($sformatf("vec%0d out_valid", i), 32'(ov4), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d in_ready", i), 32'(ir4), 32'(vecs[i].exp_ready));
      if (vecs[i].chk_data) begin
        check($sformatf("vec%0d out_data", i), od4, vecs[i].exp_data);
        check($sformatf("vec%0d out_sel_err", i), 32'(err4), 32'd0);
      end
    end
    iv4 = 1'b0; fl4 = 1'b0; or4 = 1'b1;

    // N=3: out-of-range select, then in-range, then an error flag travelling through the skid.
    sel3 = 2'd3; iv3 = 1'b1; or3 = 1'b1;
    step();
    check("n3 oor valid", 32'(ov3), 32'd1);
    check("n3 oor data", od3, 32'h0);
    check("n3 oor err", 32'(err3), 32'd1);
    sel3 = 2'd2;
    step();
    check("n3 sel2 data", od3, 32'hCCCC2222);
    check("n3 sel2 err", 32'(err3), 32'd0);
    iv3 = 1'b0;
    step();
    sel3 = 2'd1; iv3 = 1'b1; or3 = 1'b0;
    step();
    check("n3 bp head data", od3, 32'hBBBB1111);
    sel3 = 2'd3;
    step();
    check("n3 bp full", 32'(ir3), 32'd0);
    check("n3 bp hold err", 32'(err3), 32'd0);
    iv3 = 1'b0; or3 = 1'b1;
    step();
    check("n3 skid data", od3, 32'h0);
    check("n3 skid err", 32'(err3), 32'd1);
    check("n3 skid valid", 32'(ov3), 32'd1);
    step();
    check("n3 drained", 32'(ov3), 32'd0);

    // Async reset while both entries of the N=4 stage are full.
    sel4 = 2'd1; iv4 = 1'b1; or4 = 1'b0;
    step();
    sel4 = 2'd2;
    step();
    check("pre-reset full", 32'(ir4), 32'd0);
    check("pre-reset valid", 32'(ov4), 32'd1);
    iv4 = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async reset valid", 32'(ov4), 32'd0);
    check("async reset ready", 32'(ir4), 32'd1);
    check("async reset data", od4, 32'h0);
    #2 reset = 1'b0;
    sel4 = 2'd3; iv4 = 1'b1; or4 = 1'b1;
    step();
    check("post-reset valid", 32'(ov4), 32'd1);
    check("post-reset data", od4, 32'h44444444);
    iv4 = 1'b0;
    step();
    check("post-reset drain", 32'(ov4), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
- Parametrised N-way, WIDTH-bit select stage for the RISC-V datapath, generalising the fixed 32-bit 4:1 operand mux.
- Selects one of N inputs, registers the result, and carries it through a valid/ready handshake with a one-entry skid buffer, so it can sit between pipeline stages under back-pressure.
- Adds a synchronous flush for branch/exception squash.
- Flags out-of-range selects when N is not a power of two.

Parameters:
- WIDTH, 32, data width in bits of each input and of the output.
- N, 4, number of inputs; legal range 2..16.
- SEL_W, $clog2(N), select width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  N*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  index of the input to forward.
- in_valid  input  1  upstream presents in_data/sel this cycle.
- in_ready  output  1  block can accept this cycle.
- flush  input  1  synchronous squash of all held entries.
- out_data  output  WIDTH  registered selected value.
- out_sel_err  output  1  held entry was captured with sel >= N.
- out_valid  output  1  out_data/out_sel_err are valid.
- out_ready  input  1  downstream consumes when out_valid is high.

Behaviour:
- Reset is asynchronous, active-high. While reset is high:
  - out_data = 0, out_sel_err = 0, out_valid = 0.
  - Skid entry is cleared; in_ready = 1.
- Select logic is combinational:
  - sel_val = in_data[sel] when sel < N, else 0.
  - sel_err = (sel >= N); this is constant 0 when N is a power of two.
- Handshake events:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
  - advance = ~out_valid | out_ready.
- in_ready = ~skid_valid. It is a register-derived output with no combinational path from out_ready.
- Per rising edge, in priority order:
  1. flush: out_valid <= 0 and skid_valid <= 0. Any accept in the same cycle is dropped; data registers may hold stale values.
  2. advance with skid_valid: out <= skid {data, err}, out_valid <= 1, skid_valid <= 0.
  3. advance without skid_valid: out <= {sel_val, sel_err} when accept; out_valid <= accept.
  4. no advance with accept: skid <= {sel_val, sel_err}, skid_valid <= 1.
  5. otherwise: hold all state.
- Latency: 1 cycle from accept to out_valid when unstalled.
- Throughput: 1 transfer per cycle under continuous in_valid & out_ready.
- Ordering: transfers leave strictly in accept order. Nothing is lost or duplicated except on flush.
- Full condition: skid_valid = 1 → in_ready = 0. Upstream must hold in_data, sel and in_valid.
- Stability: while out_valid = 1 and out_ready = 0, out_data and out_sel_err hold stable.
- Simultaneous skid load and drain cannot occur, because in_ready is 0 whenever skid_valid is 1.
- Reset mid-transfer: all valids clear immediately (asynchronous). Held data is discarded and no output is produced for it.

Decomposition:
- Shared package riscv_pkg:
  - XLEN = 32.
  - Forwarding select constants: FWD_RF = 0, FWD_EX = 1, FWD_MEM = 2, FWD_WB = 3.
- One sub-module, pipe_skid_reg (WIDTH+1 bits, valid/ready, flush). It holds the main register, the skid register and the handshake logic.
- mux_n_pipe contains only the select/err logic plus one pipe_skid_reg instance.

Test Plan:
- Basic pass-through, N=4, WIDTH=32: inputs 0x11111111, 0x22222222, 0x33333333, 0x44444444; sel=2, in_valid=1, out_ready=1 → next cycle out_data=0x33333333, out_valid=1, out_sel_err=0.
- Streaming: sel=0,1,2,3 on consecutive cycles with out_ready=1 → out_data 0x11111111, 0x22222222, 0x33333333, 0x44444444 on the following 4 cycles; in_ready stays 1 throughout.
- Back-pressure:
  - Hold out_ready=0 and send sel=1 then sel=3 → out_data=0x22222222, skid holds 0x44444444, in_ready=0.
  - A third beat is held upstream.
  - Raise out_ready → 0x22222222, 0x44444444, then the third beat, in order.
- Out-of-range select, N=3 (SEL_W=2): sel=3 → out_data=0, out_sel_err=1. Then sel=2 → out_data = input 2, out_sel_err=0.
- Flush:
  - With out_valid=1 and skid_valid=1, assert flush for one cycle together with in_valid=1 → next cycle out_valid=0, in_ready=1.
  - The beat offered in the flush cycle never appears.
- Async reset: assert reset mid-cycle while stalled with both entries full → out_valid=0 and in_ready=1 immediately, before the next clk edge. The first accept after release produces correct data with 1-cycle latency.
